// File: rtl/full_st_out_stream_tx_pkg.sv
// Shared types for the stage result stream transmitter.
// float_24_8 word type, FSM encoding and default widths.
package full_st_out_stream_tx_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int WIDTH_W_DEF = 4;
  localparam int DEPTH_W_DEF = 3;

  typedef logic [DATA_W_DEF-1:0] float_24_8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

endpackage

// File: rtl/full_st_skid_buf2.sv
// Two-entry ready/valid skid buffer; head entry drives the output.
// Writer must never push into a full buffer without a pop.
module full_st_skid_buf2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;
  logic              pop;

  assign out_vld  = (count != 2'd0);
  assign out_data = ent0;
  assign pop      = out_vld & out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      unique case ({in_vld, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_data;
          else ent1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= in_data;
          end else begin
            ent0 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/full_st_out_stream_tx.sv
// Streams finished result rows onto the next stage's ready/valid/first bus.
// FULL_ST_TX_LAST_EN adds out_last; FULL_ST_TX_OVF_ASSERT checks row_done overflow.
module full_st_out_stream_tx
  import full_st_out_stream_tx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WIDTH_W = WIDTH_W_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH_W-1:0]         load_length,
  input  logic [DEPTH_W-1:0]         load_depth,
  input  logic                       row_done,
  output logic [DEPTH_W-1:0]         wr_row,
  output logic                       row_space,
  output logic                       mem_rd_en,
  output logic [DEPTH_W+WIDTH_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]          mem_rd_data,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_fst,
  output logic                       out_vld,
  input  logic                       out_rdy,
`ifdef FULL_ST_TX_LAST_EN
  output logic                       out_last,
`endif
  output logic                       tx_row_finish,
  output logic                       tx_busy
);

  logic [1:0]         state;
  logic [DEPTH_W-1:0] rd_row;
  logic [WIDTH_W-1:0] rd_word;
  logic [WIDTH_W-1:0] rd_word_a;
  logic [WIDTH_W-1:0] out_idx;
  logic [DEPTH_W:0]   pending;
  logic               inflight;
  logic [1:0]         buf_count;
  logic [2:0]         occ;
  logic               room;
  logic               pop;
  logic               last_hs;
  logic               row_acc;

  assign pop       = out_vld & out_rdy;
  assign last_hs   = pop & (out_idx == load_length);
  assign row_space = (pending <= {1'b0, load_depth});
  assign row_acc   = row_done & row_space;
  assign occ       = {1'b0, buf_count} + {2'b0, inflight};
  assign room      = occ < (3'd2 + {2'b0, pop});
  assign out_fst   = out_vld & (out_idx == '0);
  assign tx_busy   = (state != ST_IDLE) | (pending != '0);
`ifdef FULL_ST_TX_LAST_EN
  assign out_last  = out_vld & (out_idx == load_length);
`endif

  // A finishing row is still counted in pending; hold off until it retires.
  always_comb begin
    mem_rd_en = 1'b0;
    rd_word_a = rd_word;
    case (state)
      ST_IDLE: begin
        mem_rd_en = (pending != '0) & ~tx_row_finish;
        rd_word_a = '0;
      end
      ST_STREAM: mem_rd_en = room;
      default: ;
    endcase
  end

  assign mem_rd_addr = {rd_row, rd_word_a};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rd_row        <= '0;
      rd_word       <= '0;
      wr_row        <= '0;
      out_idx       <= '0;
      pending       <= '0;
      inflight      <= 1'b0;
      tx_row_finish <= 1'b0;
    end else begin
      inflight      <= mem_rd_en;
      tx_row_finish <= last_hs;
      if (row_acc)
        wr_row <= (wr_row == load_depth) ? '0 : wr_row + DEPTH_W'(1);
      unique case ({row_acc, tx_row_finish})
        2'b10:   pending <= pending + (DEPTH_W+1)'(1);
        2'b01:   pending <= pending - (DEPTH_W+1)'(1);
        default: ;
      endcase
      if (pop)
        out_idx <= last_hs ? '0 : out_idx + WIDTH_W'(1);
      if (last_hs)
        rd_row <= (rd_row == load_depth) ? '0 : rd_row + DEPTH_W'(1);
      case (state)
        ST_IDLE: begin
          if (mem_rd_en) begin
            rd_word <= WIDTH_W'(1);
            state   <= (load_length == '0) ? ST_DRAIN : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (mem_rd_en) begin
            rd_word <= (rd_word == load_length) ? '0 : rd_word + WIDTH_W'(1);
            if (rd_word == load_length) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (last_hs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FULL_ST_TX_OVF_ASSERT
  always_ff @(posedge clk)
    if (!reset && row_done)
      assert (row_space) else $error("row_done with no free row slot");
`endif

  full_st_skid_buf2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (inflight),
    .in_data (mem_rd_data),
    .out_vld (out_vld),
    .out_data(out_data),
    .out_rdy (out_rdy),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_full_st_out_stream_tx.sv
// Self-checking bench for full_st_out_stream_tx: timing table, corner
// sequences and randomized traffic against a queue-based row model.
module tb_full_st_out_stream_tx;
  import full_st_out_stream_tx_pkg::*;

  localparam int DW  = 32;
  localparam int WW  = 4;
  localparam int DPW = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [WW-1:0]     len_i = '0;
  logic [DPW-1:0]    depth_i = '0;
  logic              row_done = 1'b0;
  logic [DPW-1:0]    wr_row;
  logic              row_space;
  logic              mem_rd_en;
  logic [DPW+WW-1:0] mem_rd_addr;
  logic [DW-1:0]     mem_rd_data = '0;
  logic [DW-1:0]     out_data;
  logic              out_fst;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic              tx_row_finish;
  logic              tx_busy;
`ifdef FULL_ST_TX_LAST_EN
  logic              out_last;
`endif

  always #5 clk = ~clk;

  full_st_out_stream_tx dut (
    .clk          (clk),
    .reset        (reset),
    .load_length  (len_i),
    .load_depth   (depth_i),
    .row_done     (row_done),
    .wr_row       (wr_row),
    .row_space    (row_space),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_data     (out_data),
    .out_fst      (out_fst),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
`ifdef FULL_ST_TX_LAST_EN
    .out_last     (out_last),
`endif
    .tx_row_finish(tx_row_finish),
    .tx_busy      (tx_busy)
  );

  // Result memory with one-cycle read latency.
  float_24_8 mem [0:(1<<(DPW+WW))-1];
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rows as queues of expected words.
  typedef struct {
    logic [DW-1:0] data;
    logic          fst;
    logic          last;
  } word_t;

  word_t exp_q[$];
  int    rd_slot_q[$];
  int    rd_word_m = 0;
  int    pend_m = 0;
  int    wr_m = 0;
  bit    fin_pend = 0;
  bit    prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic  prev_fst;
  int    issued = 0;
  int    popped = 0;
  int    hs_cnt = 0;
  int    fin_cnt = 0;

  function automatic logic [DPW+WW-1:0] addr_of(input int slot, input int w);
    return {DPW'(slot), WW'(w)};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rd_slot_q.delete();
      rd_word_m  = 0;
      pend_m     = 0;
      wr_m       = 0;
      fin_pend   = 0;
      prev_stall = 0;
      issued     = 0;
      popped     = 0;
    end else begin
      bit new_fin;
      new_fin = 0;
      chk("row_space", 64'(row_space), 64'(pend_m <= int'(depth_i)));
      chk("wr_row", 64'(wr_row), 64'(wr_m));
      chk("tx_busy", 64'(tx_busy), 64'(pend_m != 0));
      chk("tx_row_finish", 64'(tx_row_finish), 64'(fin_pend));
      if (prev_stall) begin
        chk("stall_vld", 64'(out_vld), 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_fst", 64'(out_fst), 64'(prev_fst));
      end
      if (mem_rd_en) begin
        issued++;
        if (rd_slot_q.size() == 0) begin
          chk("spurious_read", 64'(mem_rd_addr), 64'hdead);
        end else begin
          chk("rd_addr", 64'(mem_rd_addr), 64'(addr_of(rd_slot_q[0], rd_word_m)));
          if (rd_word_m == int'(len_i)) begin
            void'(rd_slot_q.pop_front());
            rd_word_m = 0;
          end else begin
            rd_word_m++;
          end
        end
      end
      if (out_vld && out_rdy) begin
        popped++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_word", 64'(out_data), 64'hdead);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_fst", 64'(out_fst), 64'(e.fst));
`ifdef FULL_ST_TX_LAST_EN
          chk("out_last", 64'(out_last), 64'(e.last));
`endif
          new_fin = e.last;
        end
      end
      chk("outstanding", 64'(issued - popped <= 2), 64'd1);
      if (row_done && pend_m <= int'(depth_i)) begin
        rd_slot_q.push_back(wr_m);
        for (int w = 0; w <= int'(len_i); w++)
          exp_q.push_back('{mem[addr_of(wr_m, w)], w == 0, w == int'(len_i)});
        pend_m++;
        wr_m = (wr_m == int'(depth_i)) ? 0 : wr_m + 1;
      end
      if (fin_pend) begin
        pend_m--;
        fin_cnt++;
      end
      fin_pend   = new_fin;
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
      prev_fst   = out_fst;
    end
  end

  // One clock of stimulus; upstream fills the slot only if it is free.
  task automatic cycle(input bit rd, input bit rdy);
    @(posedge clk);
    #1;
    row_done = rd;
    out_rdy  = rdy;
    if (rd && pend_m <= int'(depth_i))
      for (int w = 0; w <= int'(len_i); w++)
        mem[addr_of(wr_m, w)] = $urandom;
  endtask

  task automatic do_reset(input int l, input int d);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    row_done = 1'b0;
    out_rdy  = 1'b0;
    len_i    = WW'(l);
    depth_i  = DPW'(d);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle(0, 1);
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && pend_m == 0 && !fin_pend) done = 1;
    end
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  typedef struct {
    logic         rd_en;
    logic [WW-1:0] word;
    logic         vld;
    logic         fst;
    logic         fin;
  } vec_t;

  vec_t vec[9];
  bit   pat[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, f0, k;
    // Single row timing, row_done at t.
    vec[0] = '{0, 0, 0, 0, 0};
    vec[1] = '{1, 0, 0, 0, 0};
    vec[2] = '{1, 1, 0, 0, 0};
    vec[3] = '{1, 2, 1, 1, 0};
    vec[4] = '{1, 3, 1, 0, 0};
    vec[5] = '{0, 0, 1, 0, 0};
    vec[6] = '{0, 0, 1, 0, 0};
    vec[7] = '{0, 0, 0, 0, 1};
    vec[8] = '{0, 0, 0, 0, 0};

    do_reset(3, 7);
    @(negedge clk);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_space", 64'(row_space), 64'd1);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_busy", 64'(tx_busy), 64'd0);
    cycle(0, 1);
    cycle(1, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cycle(0, 1);
      @(negedge clk);
      chk($sformatf("t%0d_rd_en", i), 64'(mem_rd_en), 64'(vec[i].rd_en));
      if (vec[i].rd_en)
        chk($sformatf("t%0d_addr", i), 64'(mem_rd_addr), 64'(addr_of(0, int'(vec[i].word))));
      chk($sformatf("t%0d_vld", i), 64'(out_vld), 64'(vec[i].vld));
      chk($sformatf("t%0d_fst", i), 64'(out_fst), 64'(vec[i].fst));
      chk($sformatf("t%0d_fin", i), 64'(tx_row_finish), 64'(vec[i].fin));
    end

    // Backpressure with out_rdy pattern 1,0,0,1.
    do_reset(15, 7);
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    h0 = hs_cnt;
    k  = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(i < 2, pat[i % 4]);
      @(negedge clk);
      #1;
      if (i > 2 && exp_q.size() == 0 && pend_m == 0 && !fin_pend) break;
      k = i;
    end
    chk("bp_words", 64'(hs_cnt - h0), 64'd32);
    chk("bp_timeout", 64'(k < 399), 64'd1);

    // Fill three slots, fourth row_done is ignored, then drain and wrap.
    do_reset(1, 2);
    f0 = fin_cnt;
    for (int i = 0; i < 4; i++) cycle(1, 0);
    @(negedge clk);
    chk("full_space", 64'(row_space), 64'd0);
    chk("full_wr_row", 64'(wr_row), 64'd0);
    cycle(0, 0);
    drain(200);
    chk("full_fin", 64'(fin_cnt - f0), 64'd3);
    chk("wrap_wr_row", 64'(wr_row), 64'd0);
    cycle(1, 1);
    cycle(0, 1);
    @(negedge clk);
    chk("wrap_rd_en", 64'(mem_rd_en), 64'd1);
    chk("wrap_addr", 64'(mem_rd_addr), 64'(addr_of(0, 0)));
    drain(100);

    // row_done in the same cycle as tx_row_finish.
    do_reset(3, 1);
    cycle(1, 1);
    for (int i = 1; i <= 14; i++) begin
      cycle(i == 7, 1);
      @(negedge clk);
      if (i == 7) begin
        chk("sim_fin", 64'(tx_row_finish), 64'd1);
        chk("sim_space", 64'(row_space), 64'd1);
      end
      if (i >= 7) chk($sformatf("sim_busy%0d", i), 64'(tx_busy), 64'd1);
      if (i == 8) chk("sim_addr", 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, addr_of(1, 0)}));
      if (i >= 8) chk($sformatf("sim_vld%0d", i), 64'(out_vld), 64'(i >= 10 && i <= 13));
      if (i == 14) chk("sim_fin2", 64'(tx_row_finish), 64'd1);
    end
    drain(50);

    // Single-word rows.
    do_reset(0, 3);
    h0 = hs_cnt;
    f0 = fin_cnt;
    for (int i = 0; i < 3; i++) cycle(1, 1);
    drain(100);
    chk("len0_words", 64'(hs_cnt - h0), 64'd3);
    chk("len0_fin", 64'(fin_cnt - f0), 64'd3);

    // Reset in the middle of a 16-word row.
    do_reset(15, 7);
    h0 = hs_cnt;
    cycle(1, 1);
    for (int i = 0; i < 50; i++) begin
      cycle(0, 1);
      @(negedge clk);
      #1;
      if (hs_cnt - h0 >= 6) break;
    end
    chk("mid_words", 64'(hs_cnt - h0), 64'd6);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_vld", 64'(out_vld), 64'd0);
    chk("mid_fst", 64'(out_fst), 64'd0);
    chk("mid_data", 64'(out_data), 64'd0);
    chk("mid_rd", 64'({mem_rd_en, mem_rd_addr}), 64'd0);
    chk("mid_space", 64'({row_space, wr_row, tx_busy, tx_row_finish}), 64'({1'b1, 3'd0, 1'b0, 1'b0}));
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1);
      @(negedge clk);
      chk("mid_quiet", 64'({out_vld, tx_row_finish, mem_rd_en}), 64'd0);
    end
    cycle(1, 1);
    cycle(0, 1);
    @(negedge clk);
    chk("mid_restart", 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, addr_of(0, 0)}));
    drain(100);

    // Randomized traffic.
    for (int c = 0; c < 4; c++) begin
      do_reset(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      for (int i = 0; i < 300; i++)
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      drain(2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
